// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequenced CORDIC engine, one shared shift/add datapath, valid/ready in and out.
// Define CORDIC_GAIN_COMP_EN to add a post-rotation 1/K gain compensation state.
module cordic_iter_ctrl #(
    parameter  int unsigned ITER = 14,
    localparam int unsigned DW   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_y,
    input  logic signed [DW-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_x,
    output logic signed [DW-1:0] out_y,
    output logic signed [DW-1:0] out_z
);

    localparam int unsigned IW = 4;
    localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_COMP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t               state, state_next;
    logic [IW-1:0]        iter, iter_next;
    logic signed [DW-1:0] x, y, z;
    logic signed [DW-1:0] x_next, y_next, z_next;
    logic                 mode, mode_next;
    logic signed [DW-1:0] x_sh, y_sh, atan_i;
    logic                 dir_pos;

    // Elementary angles atan(2^-i), 1 LSB = pi/32768
    function automatic logic signed [DW-1:0] atan_lut(input logic [IW-1:0] idx);
        case (idx)
            4'd0:    atan_lut = 16'sd8192;
            4'd1:    atan_lut = 16'sd4836;
            4'd2:    atan_lut = 16'sd2555;
            4'd3:    atan_lut = 16'sd1297;
            4'd4:    atan_lut = 16'sd651;
            4'd5:    atan_lut = 16'sd326;
            4'd6:    atan_lut = 16'sd163;
            4'd7:    atan_lut = 16'sd81;
            4'd8:    atan_lut = 16'sd41;
            4'd9:    atan_lut = 16'sd20;
            4'd10:   atan_lut = 16'sd10;
            4'd11:   atan_lut = 16'sd5;
            4'd12:   atan_lut = 16'sd3;
            4'd13:   atan_lut = 16'sd1;
            4'd14:   atan_lut = 16'sd1;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    // 1/K ~= 0.607422 as a four-term shift-add
    function automatic logic signed [DW-1:0] gain_comp(input logic signed [DW-1:0] v);
        gain_comp = (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            iter      <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            mode      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            iter      <= iter_next;
            x         <= x_next;
            y         <= y_next;
            z         <= z_next;
            mode      <= mode_next;
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);
        end
    end

    always_comb begin
        state_next = state;
        iter_next  = iter;
        x_next     = x;
        y_next     = y;
        z_next     = z;
        mode_next  = mode;
        x_sh       = x >>> iter;
        y_sh       = y >>> iter;
        atan_i     = atan_lut(iter);
        dir_pos    = mode ? y[DW-1] : ~z[DW-1];

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    x_next     = in_x;
                    y_next     = in_y;
                    z_next     = in_z;
                    mode_next  = in_mode;
                    iter_next  = '0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // One micro-rotation; all sums wrap modulo 2^16
                x_next    = dir_pos ? (x - y_sh) : (x + y_sh);
                y_next    = dir_pos ? (y + x_sh) : (y - x_sh);
                z_next    = dir_pos ? (z - atan_i) : (z + atan_i);
                iter_next = iter + 4'd1;
                if (iter == ITER_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = S_COMP;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: begin
                x_next     = gain_comp(x);
                y_next     = gain_comp(y);
                state_next = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign out_x = x;
    assign out_y = y;
    assign out_z = z;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: a 14-iteration instance and a 1-iteration instance.
// Expectations follow CORDIC_GAIN_COMP_EN when it is defined for the build.
module tb_cordic_iter_ctrl;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT14   = 15;
    localparam int LAT1    = 2;
    localparam int ROT_XY  = 7074;
    localparam int ROT_TOL = 12;
    localparam int VEC_X   = 14146;
    localparam int VEC_TOL = 14;
    localparam int UNIT_XY = 0;
    localparam int ONE_XY  = 6075;
`else
    localparam int LAT14   = 14;
    localparam int LAT1    = 1;
    localparam int ROT_XY  = 11645;
    localparam int ROT_TOL = 8;
    localparam int VEC_X   = 23289;
    localparam int VEC_TOL = 8;
    localparam int UNIT_XY = 1;
    localparam int ONE_XY  = 10000;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid, in_valid1;
    logic               in_ready, in_ready1;
    logic               in_mode;
    logic signed [15:0] in_x, in_y, in_z;
    logic               out_valid, out_valid1;
    logic               out_ready, out_ready1;
    logic signed [15:0] out_x, out_y, out_z;
    logic signed [15:0] out_x1, out_y1, out_z1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cordic_iter_ctrl #(.ITER(14)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    cordic_iter_ctrl #(.ITER(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_x(out_x1), .out_y(out_y1), .out_z(out_z1)
    );

    task automatic check(input string tag, input int actual, input int lo, input int hi);
        n_checks++;
        if (actual < lo || actual > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", tag, actual, lo, hi);
        end
    endtask

    // Offer one operand set at a negedge; return edges-to-out_valid and the held result
    task automatic run_op(input bit sel, input bit mode, input int xv, input int yv, input int zv,
                          output int lat, output int rx, output int ry, output int rz);
        in_mode = mode;
        in_x    = 16'(xv);
        in_y    = 16'(yv);
        in_z    = 16'(zv);
        if (sel) in_valid1 = 1'b1;
        else     in_valid  = 1'b1;
        @(negedge clock);
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        lat = 0;
        while (!(sel ? out_valid1 : out_valid) && lat < 64) begin
            @(negedge clock);
            lat++;
        end
        rx = sel ? int'(out_x1) : int'(out_x);
        ry = sel ? int'(out_y1) : int'(out_y);
        rz = sel ? int'(out_z1) : int'(out_z);
    endtask

    task automatic handshake(input bit sel, input string tag);
        if (sel) out_ready1 = 1'b1;
        else     out_ready  = 1'b1;
        @(negedge clock);
        out_ready  = 1'b0;
        out_ready1 = 1'b0;
        check({tag, "_valid_drop"}, int'(sel ? out_valid1 : out_valid), 0, 0);
        check({tag, "_ready_back"}, int'(sel ? in_ready1 : in_ready), 1, 1);
    endtask

    initial begin
        int lat, rx, ry, rz;
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_valid1  = 1'b1;
        out_ready  = 1'b1;
        out_ready1 = 1'b1;
        in_mode    = 1'b0;
        in_x       = 16'sd1234;
        in_y       = 16'sd567;
        in_z       = 16'sd89;
        repeat (3) @(negedge clock);
        check("rst_in_ready", int'(in_ready), 1, 1);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_out_x", out_x, 0, 0);
        check("rst_out_y", out_y, 0, 0);
        check("rst_out_z", out_z, 0, 0);
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        out_ready  = 1'b0;
        out_ready1 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_no_accept", int'(out_valid), 0, 0);
        check("rst_still_ready", int'(in_ready), 1, 1);

        // Rotation by pi/4
        run_op(0, 1'b0, 10000, 0, 8192, lat, rx, ry, rz);
        check("rot_latency", lat, LAT14, LAT14);
        check("rot_x", rx, ROT_XY - ROT_TOL, ROT_XY + ROT_TOL);
        check("rot_y", ry, ROT_XY - ROT_TOL, ROT_XY + ROT_TOL);
        check("rot_z", rz, -4, 4);
        handshake(0, "rot");

        // Vectoring of (1,1)*10000
        run_op(0, 1'b1, 10000, 10000, 0, lat, rx, ry, rz);
        check("vec_latency", lat, LAT14, LAT14);
        check("vec_z", rz, 8188, 8196);
        check("vec_x", rx, VEC_X - VEC_TOL, VEC_X + VEC_TOL);
        check("vec_y", ry, -4, 4);
        handshake(0, "vec");

        // Unit vector at angle 0: z walks the whole ATAN table to -1
        run_op(0, 1'b0, 1, 0, 0, lat, rx, ry, rz);
        check("unit_x", rx, UNIT_XY, UNIT_XY);
        check("unit_y", ry, UNIT_XY, UNIT_XY);
        check("unit_z", rz, -1, -1);
        handshake(0, "unit");

        // Single-iteration instance: exactly one micro-rotation
        run_op(1, 1'b0, 10000, 0, 8192, lat, rx, ry, rz);
        check("iter1_latency", lat, LAT1, LAT1);
        check("iter1_x", rx, ONE_XY, ONE_XY);
        check("iter1_y", ry, ONE_XY, ONE_XY);
        check("iter1_z", rz, 0, 0);
        handshake(1, "iter1");

        // Backpressure with an in_valid pulse while the result is held
        run_op(0, 1'b1, 10000, 10000, 0, lat, rx, ry, rz);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 2);
            in_x     = 16'sd5;
            in_y     = 16'sd7;
            in_z     = 16'sd9;
            @(negedge clock);
            check("bp_valid", int'(out_valid), 1, 1);
            check("bp_in_ready", int'(in_ready), 0, 0);
            check("bp_x_stable", out_x, rx, rx);
            check("bp_y_stable", out_y, ry, ry);
            check("bp_z_stable", out_z, rz, rz);
        end
        in_valid = 1'b0;
        handshake(0, "bp");
        repeat (LAT14 + 2) @(negedge clock);
        check("bp_no_accept", int'(out_valid), 0, 0);

        // Reset during the 5th RUN cycle discards the operation
        in_mode  = 1'b0;
        in_x     = 16'sd10000;
        in_y     = 16'sd0;
        in_z     = 16'sd8192;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_in_ready", int'(in_ready), 1, 1);
        check("mid_rst_out_valid", int'(out_valid), 0, 0);
        check("mid_rst_x", out_x, 0, 0);
        check("mid_rst_y", out_y, 0, 0);
        check("mid_rst_z", out_z, 0, 0);
        reset = 1'b0;
        repeat (LAT14 + 2) @(negedge clock);
        check("mid_rst_no_result", int'(out_valid), 0, 0);

        run_op(0, 1'b0, 10000, 0, 8192, lat, rx, ry, rz);
        check("post_rst_latency", lat, LAT14, LAT14);
        check("post_rst_x", rx, ROT_XY - ROT_TOL, ROT_XY + ROT_TOL);
        check("post_rst_y", ry, ROT_XY - ROT_TOL, ROT_XY + ROT_TOL);
        check("post_rst_z", rz, -4, 4);
        handshake(0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
